// File: rtl/frame_fifo_sf.sv
`timescale 1ns/1ps
// Frame-aware store-and-forward FIFO: per-frame length descriptors, drop-by-rewind
// for errored/overflowing frames, almost-full pause pulse. Stats: FRAME_FIFO_STATS_EN.
module frame_fifo_sf #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 11,
    parameter int DESC_AW   = 4,
    parameter int AFULL_LVL = 1536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    input  logic              wr_last,
    input  logic              wr_err,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic [15:0]       rd_frm_len,
    output logic              frm_avail,
    output logic              afull,
    output logic              pause_req,
    output logic              drop_pulse,
    output logic [ADDR_W:0]   fill
`ifdef FRAME_FIFO_STATS_EN
    ,
    output logic [31:0]       stat_frames,
    output logic [31:0]       stat_drops
`endif
);

    typedef enum logic [1:0] {WR_IDLE, WR_FRAME, WR_DROP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_LOAD, RD_SEND} rd_state_t;

    localparam logic [ADDR_W:0]  DEPTH      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  AFULL_THR  = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0]  PTR_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]  PTR_TWO    = {{(ADDR_W-1){1'b0}}, 2'b10};
    localparam logic [DESC_AW:0] DESC_DEPTH = {1'b1, {DESC_AW{1'b0}}};
    localparam logic [DESC_AW:0] DESC_ONE   = {{DESC_AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem      [0:(1<<ADDR_W)-1];
    logic [15:0]       desc_mem [0:(1<<DESC_AW)-1];

    wr_state_t         wr_state_q, wr_state_d;
    rd_state_t         rd_state_q, rd_state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]       cur_len_q, cur_len_d, remain_q, remain_d, rd_len_q, rd_len_d;
    logic [DESC_AW:0]  dwr_ptr_q, dwr_ptr_d, drd_ptr_q, drd_ptr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d, ram_q;
    logic              rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic              drop_q, drop_d, frm_avail_q, afull_q, afull_dly_q;
    logic              ram_we, ram_re, desc_push, desc_pop, full, desc_full;
    logic [ADDR_W-1:0] ram_raddr;
    logic [ADDR_W:0]   fill_w;
    logic [DESC_AW:0]  desc_cnt;
    logic [15:0]       len_inc, desc_head;

    assign fill_w    = wr_ptr_q - rd_ptr_q;
    assign full      = (fill_w == DEPTH);
    assign desc_cnt  = dwr_ptr_q - drd_ptr_q;
    assign desc_full = (desc_cnt == DESC_DEPTH);
    assign len_inc   = (cur_len_q == 16'hFFFF) ? 16'hFFFF : cur_len_q + 16'd1;
    assign desc_head = desc_mem[drd_ptr_q[DESC_AW-1:0]];

    // Write side: a rejected frame rewinds wr_ptr to the last commit point.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_ptr_d   = wr_ptr_q;
        cm_ptr_d   = cm_ptr_q;
        cur_len_d  = cur_len_q;
        drop_d     = 1'b0;
        ram_we     = 1'b0;
        desc_push  = 1'b0;
        case (wr_state_q)
            WR_IDLE, WR_FRAME: begin
                if (wr_valid) begin
                    if (full) begin
                        wr_ptr_d   = cm_ptr_q;
                        cur_len_d  = 16'd0;
                        drop_d     = 1'b1;
                        wr_state_d = wr_last ? WR_IDLE : WR_DROP;
                    end else if (wr_last) begin
                        ram_we = 1'b1;
                        if (!wr_err && !desc_full) begin
                            desc_push = 1'b1;
                            wr_ptr_d  = wr_ptr_q + PTR_ONE;
                            cm_ptr_d  = wr_ptr_q + PTR_ONE;
                        end else begin
                            wr_ptr_d = cm_ptr_q;
                            drop_d   = 1'b1;
                        end
                        cur_len_d  = 16'd0;
                        wr_state_d = WR_IDLE;
                    end else begin
                        ram_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_q + PTR_ONE;
                        cur_len_d  = len_inc;
                        wr_state_d = WR_FRAME;
                    end
                end
            end
            WR_DROP: begin
                if (wr_valid && wr_last) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Read side: ram_q always holds the word after rd_data so a transfer can refill at once.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_ptr_d   = rd_ptr_q;
        remain_d   = remain_q;
        rd_len_d   = rd_len_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        ram_re     = 1'b0;
        ram_raddr  = rd_ptr_q[ADDR_W-1:0];
        desc_pop   = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (frm_avail_q) begin
                    rd_len_d   = desc_head;
                    remain_d   = desc_head;
                    ram_re     = 1'b1;
                    rd_state_d = RD_LOAD;
                end
            end
            RD_LOAD: begin
                rd_data_d  = ram_q;
                rd_valid_d = 1'b1;
                rd_last_d  = (remain_q == 16'd1);
                ram_re     = 1'b1;
                ram_raddr  = ADDR_W'(rd_ptr_q + PTR_ONE);
                rd_state_d = RD_SEND;
            end
            RD_SEND: begin
                if (rd_ready) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    remain_d = remain_q - 16'd1;
                    if (rd_last_q) begin
                        desc_pop   = 1'b1;
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        rd_state_d = RD_IDLE;
                    end else begin
                        rd_data_d = ram_q;
                        rd_last_d = (remain_q == 16'd2);
                        ram_re    = 1'b1;
                        ram_raddr = ADDR_W'(rd_ptr_q + PTR_TWO);
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    assign dwr_ptr_d = desc_push ? dwr_ptr_q + DESC_ONE : dwr_ptr_q;
    assign drd_ptr_d = desc_pop  ? drd_ptr_q + DESC_ONE : drd_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q  <= WR_IDLE;
            rd_state_q  <= RD_IDLE;
            wr_ptr_q    <= '0;
            cm_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cur_len_q   <= '0;
            remain_q    <= '0;
            rd_len_q    <= '0;
            dwr_ptr_q   <= '0;
            drd_ptr_q   <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            drop_q      <= 1'b0;
            frm_avail_q <= 1'b0;
            afull_q     <= 1'b0;
            afull_dly_q <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            wr_ptr_q    <= wr_ptr_d;
            cm_ptr_q    <= cm_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cur_len_q   <= cur_len_d;
            remain_q    <= remain_d;
            rd_len_q    <= rd_len_d;
            dwr_ptr_q   <= dwr_ptr_d;
            drd_ptr_q   <= drd_ptr_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            drop_q      <= drop_d;
            frm_avail_q <= (dwr_ptr_d != drd_ptr_d);
            afull_q     <= (fill_w >= AFULL_THR);
            afull_dly_q <= afull_q;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)    mem[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
        if (ram_re)    ram_q <= mem[ram_raddr];
        if (desc_push) desc_mem[dwr_ptr_q[DESC_AW-1:0]] <= len_inc;
    end

`ifdef FRAME_FIFO_STATS_EN
    logic [31:0] stat_frames_q, stat_drops_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames_q <= '0;
            stat_drops_q  <= '0;
        end else begin
            if (desc_push) stat_frames_q <= stat_frames_q + 32'd1;
            if (drop_d)    stat_drops_q  <= stat_drops_q + 32'd1;
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_drops  = stat_drops_q;
`endif

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign rd_last    = rd_last_q;
    assign rd_frm_len = rd_len_q;
    assign frm_avail  = frm_avail_q;
    assign afull      = afull_q;
    assign pause_req  = afull_q & ~afull_dly_q;
    assign drop_pulse = drop_q;
    assign fill       = fill_w;

endmodule

// File: doc/frame_fifo_sf.md
Name: frame_fifo_sf

Overview:
- Parametrised, frame-aware store-and-forward buffer between the MAC receive byte stream and the transmit controller.
- Generalises the current byte FIFO in three ways:
  - configurable data width and depth;
  - a frame-length descriptor queue, so the TX side gets each frame's length with the frame instead of from a separate status strobe;
  - errored or overflowing frames are dropped by rewinding the write pointer, and an almost-full watermark raises a pause request.
- Single clock domain.

Parameters:
- DATA_W, 8, width of one data word.
- ADDR_W, 11, data RAM depth = 2**ADDR_W words.
- DESC_AW, 4, descriptor queue depth = 2**DESC_AW frames.
- AFULL_LVL, 1536, fill level (words) at or above which afull asserts.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_data  in  DATA_W  receive word from MAC.
- wr_valid  in  1  wr_data valid this cycle.
- wr_last  in  1  final word of frame; qualified by wr_valid.
- wr_err  in  1  frame bad (CRC/PHY error); sampled with wr_last.
- rd_data  out  DATA_W  word to TX controller.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts rd_data.
- rd_last  out  1  rd_data is last word of frame.
- rd_frm_len  out  16  word count of the frame being read; stable from first rd_valid to final transfer.
- frm_avail  out  1  at least one complete frame stored.
- afull  out  1  fill >= AFULL_LVL.
- pause_req  out  1  one-cycle pulse on afull rising edge.
- drop_pulse  out  1  one-cycle pulse when a frame is discarded.
- fill  out  ADDR_W+1  words held, committed plus uncommitted.

Behaviour:
- Reset values: all outputs 0; all pointers 0; write FSM WR_IDLE; read FSM RD_IDLE.
- Pointers:
  - wr_ptr: next write location.
  - cm_ptr: start of the current uncommitted frame.
  - rd_ptr: next read location.
  - All are ADDR_W+1 bits with a wrap bit.
  - fill = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
  - full when fill == 2**ADDR_W.
- Write FSM, states WR_IDLE/WR_FRAME/WR_DROP:
  - WR_IDLE or WR_FRAME, wr_valid and not full: write RAM[wr_ptr]; wr_ptr++; cur_len++; state -> WR_FRAME.
  - wr_valid while full: discard word; wr_ptr <= cm_ptr; cur_len <= 0; drop_pulse = 1. State -> WR_DROP, or WR_IDLE if wr_last.
  - wr_last accepted with wr_err = 0 and descriptor queue not full: push cur_len+1; cm_ptr <= wr_ptr+1; cur_len <= 0; state -> WR_IDLE.
  - wr_last with wr_err = 1, or descriptor queue full: wr_ptr <= cm_ptr; cur_len <= 0; drop_pulse = 1; state -> WR_IDLE.
  - WR_DROP: ignore all words; on wr_valid & wr_last -> WR_IDLE. No second drop_pulse.
  - cur_len saturates at 16'hFFFF.
  - A frame longer than 2**ADDR_W words always overflows and is dropped.
- Descriptor queue:
  - 2**DESC_AW entries of 16 bits, circular.
  - frm_avail = queue not empty (registered).
  - A push in cycle T makes frm_avail = 1 at T+1.
- Read FSM, states RD_IDLE/RD_LOAD/RD_SEND:
  - RD_IDLE with frm_avail: latch head descriptor into rd_frm_len; issue RAM read at rd_ptr; remain = length. -> RD_LOAD.
  - RD_LOAD: RAM output registered. rd_valid <= 1; rd_last <= (remain == 1). -> RD_SEND.
  - RD_SEND:
    - rd_valid && rd_ready transfers a word; rd_ptr++; remain--.
    - The next word is prefetched so back-to-back transfers sustain 1 word/clk.
    - rd_data, rd_valid and rd_last hold while rd_ready = 0.
    - On the rd_last transfer: pop descriptor; rd_valid <= 0; -> RD_IDLE.
    - Minimum one idle cycle between frames.
  - Latency: descriptor push at T -> first rd_valid at T+3.
- Space freed by a read at cycle T is visible to the write side at T+1.
- A simultaneous read and write in the same cycle are both honoured.
- afull is registered from fill; pause_req = afull & ~afull_q.
- Asynchronous reset mid-frame: the partial frame is lost; all state returns to reset values; no drop_pulse.

Optional Feature:
- Macro FRAME_FIFO_STATS_EN.
- When defined, adds output ports stat_frames [31:0] and stat_drops [31:0]:
  - stat_frames increments on each committed frame.
  - stat_drops increments on each drop_pulse.
  - Both wrap at 2**32; reset to 0.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Single 64-word good frame (0x00..0x3F), rd_ready = 1:
  - frm_avail rises 1 cycle after last write;
  - rd_frm_len = 64;
  - 64 consecutive transfers, rd_last only on 0x3F;
  - fill returns to 0.
- Frame of 10 words with wr_err = 1 on wr_last:
  - drop_pulse once;
  - frm_avail stays 0;
  - fill returns to 0 the cycle after wr_last.
- Fill with rd_ready = 0 until fill reaches 1536:
  - afull = 1, pause_req high exactly one cycle;
  - then a 600-word frame overflows at 2048: drop_pulse once, earlier committed frames intact.
- 17 back-to-back 4-word frames with rd_ready = 0 (DESC_AW = 4):
  - frames 1-16 committed, frame 17 dropped;
  - then rd_ready = 1 yields 16 frames, each rd_frm_len = 4.
- Random rd_ready toggling during a 100-word frame:
  - data order and values exact;
  - outputs stable while rd_ready = 0.
- Assert rst_n low mid-write and mid-read:
  - all outputs 0 immediately;
  - after release, a new 8-word frame passes correctly.
